gemm_tile_sched: RTL and testbench
==================================

// Module: gemm_tile_sched
// PURPOSE
//  Sequencer for the GEMM core: walks weight column tiles and im2col row tiles, issues BRAM0 (ifmap)
//  and BRAM1 (weight) reads, controls the PE_SIZE x PE_SIZE array (weight preload, feed, accumulate
//  clear), and writes finished output rows to BRAM2. Sits between gemm_start_i and the array/BRAMs.
// PARAMETERS
//  PE_SIZE          14    array edge; cycles per weight load, ifmap feed and output write
//  ROW_TILES        21    im2col row tiles (WEIGHT_ROW_NUM/PE_SIZE)
//  COL_TILES        5     weight column tiles (WEIGHT_COL_NUM/PE_SIZE)
//  DRAIN_CYC        28    wait after feed for systolic skew to flush (>=2*PE_SIZE-1)
//  MEM0_ADDR_WIDTH  13    ifmap BRAM address width
//  MEM1_ADDR_WIDTH  11    weight BRAM address width
//  MEM2_ADDR_WIDTH  10    actmap BRAM address width
// PORTS
//  clk            in   1    clock
//  rst_n          in   1    async active-low reset
//  gemm_start_i   in   1    start pulse; sampled only in IDLE
//  gemm_busy_o    out  1    high from cycle after start accepted until done pulse
//  gemm_done_o    out  1    1-cycle pulse after last BRAM2 write
//  mem0_ce0_o     out  1    ifmap read enable
//  mem0_we0_o     out  1    tied 0
//  mem0_addr0_o   out  MEM0_ADDR_WIDTH  ifmap read address
//  mem1_ce0_o     out  1    weight read enable
//  mem1_we0_o     out  1    tied 0
//  mem1_addr0_o   out  MEM1_ADDR_WIDTH  weight read address
//  w_load_o       out  1    weight data valid to array (mem1_ce0_o delayed 1 cycle)
//  ifmap_vld_o    out  1    ifmap data valid to array (mem0_ce0_o delayed 1 cycle)
//  acc_clr_o      out  1    1-cycle clear of array accumulators
//  out_sel_o      out  $clog2(PE_SIZE)  array output row routed to BRAM2 data
//  mem2_ce0_o     out  1    actmap enable
//  mem2_we0_o     out  1    actmap write enable (equals mem2_ce0_o)
//  mem2_addr0_o   out  MEM2_ADDR_WIDTH  actmap write address
// BEHAVIOUR
//  - Reset: state IDLE, all counters 0, every output 0. Reset mid-run aborts immediately; no done pulse.
//  - All outputs registered. BRAM read latency 1: *_vld/w_load follow ce by exactly 1 cycle.
//  - Counters: ct (col tile 0..COL_TILES-1), rt (row tile 0..ROW_TILES-1), k (0..PE_SIZE-1), d (drain).
//  - FSM:
//    IDLE  : gemm_start_i=1 -> LOAD_W, ct=rt=k=0, acc_clr_o=1 next cycle. Start while busy ignored.
//    LOAD_W: PE_SIZE cycles, mem1_ce0_o=1, mem1_addr0_o=(ct*ROW_TILES+rt)*PE_SIZE+k; k==P-1 -> FEED.
//    FEED  : PE_SIZE cycles, mem0_ce0_o=1, mem0_addr0_o=rt*PE_SIZE+k; k==P-1 -> DRAIN, d=0.
//    DRAIN : DRAIN_CYC cycles, no ce. At end: rt<ROW_TILES-1 -> rt++, LOAD_W (no clear);
//            else -> WRITE, k=0.
//    WRITE : PE_SIZE cycles, mem2_ce0_o=mem2_we0_o=1, out_sel_o=k, mem2_addr0_o=ct*PE_SIZE+k.
//            End: ct<COL_TILES-1 -> ct++, rt=0, LOAD_W with acc_clr_o pulse; else -> DONE.
//    DONE  : gemm_done_o=1 one cycle -> IDLE.
//  - acc_clr_o asserted only on first LOAD_W cycle of each column tile (rt==0, k==0).
//  - Never two BRAM ce's active in same cycle. Addresses only change while the matching ce is high;
//    hold last value otherwise.
//  - Latency start->done pulse = COL_TILES*(ROW_TILES*(2*PE_SIZE+DRAIN_CYC)+PE_SIZE)+2 cycles.
//  - Address arithmetic done at full width then truncated; parameters must fit (checked by assertion).
// STRUCTURE
//  - gemm_pkg: state enum (IDLE,LOAD_W,FEED,DRAIN,WRITE,DONE), derived tile/depth localparams.
//  - Sub-module gemm_loop_cnt: parameterised wrap counter (en, clr, max) -> cnt, last; instanced for
//    k, d, rt, ct. Address generation and FSM in this module.
// TESTING (bench params P=2, ROW_TILES=2, COL_TILES=2, DRAIN_CYC=4 unless noted)
//  - Full run: start pulse -> done 38 cycles later; mem1 addrs 0..7 in order, mem0 0,1,2,3 twice.
//  - Write check: mem2 writes at 0,1 (ct=0) then 2,3 (ct=1) with out_sel 0,1; exactly 4 writes.
//  - Clear check: acc_clr_o pulses exactly twice, each coincident with mem1 addr 0 and 4.
//  - Start while busy: extra start pulses mid-run -> trace identical, single done pulse.
//  - Reset mid-FEED: rst_n low 1 cycle -> all outputs 0, IDLE; next start gives clean 38-cycle run.
//  - Default params: done after 5*(21*56+14)+2=5952 cycles; max mem1 addr 1469, mem2 addr 69.

Source files
------------

// File: rtl/gemm_tile_sched_pkg.sv
// Shared types and helpers for the GEMM tile sequencer: FSM state encoding,
// counter sizing and the start-to-done cycle count.
package gemm_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_W,
      FEED,
      DRAIN,
      WRITE,
      DONE
   } state_t;

   localparam int DEF_PE_SIZE   = 14;
   localparam int DEF_ROW_TILES = 21;
   localparam int DEF_COL_TILES = 5;
   localparam int DEF_DRAIN_CYC = 28;

   // Width of a counter that walks 0..n-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int run_cycles(input int p, input int r, input int c, input int d);
      return c * (r * (2 * p + d) + p) + 2;
   endfunction

endpackage

// File: rtl/gemm_tile_sched_loop_cnt.sv
// Wrap-around loop counter: counts 0..max while en is high, wraps to 0 after
// max, and flags the terminal value on last.
module gemm_loop_cnt #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic [WIDTH-1:0] max,
   output logic [WIDTH-1:0] cnt,
   output logic             last
);

   logic [WIDTH-1:0] cnt_reg;

   assign cnt  = cnt_reg;
   assign last = (cnt_reg == max);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
      end else if (clr) begin
         cnt_reg <= '0;
      end else if (en) begin
         cnt_reg <= last ? '0 : cnt_reg + WIDTH'(1);
      end
   end

endmodule

// File: rtl/gemm_tile_sched.sv
// GEMM tile sequencer: walks column/row tiles, issues weight and ifmap BRAM
// reads, steers the PE array and writes finished output rows to BRAM2.
module gemm_tile_sched
   import gemm_pkg::*;
#(
   parameter int PE_SIZE         = DEF_PE_SIZE,
   parameter int ROW_TILES       = DEF_ROW_TILES,
   parameter int COL_TILES       = DEF_COL_TILES,
   parameter int DRAIN_CYC       = DEF_DRAIN_CYC,
   parameter int MEM0_ADDR_WIDTH = 13,
   parameter int MEM1_ADDR_WIDTH = 11,
   parameter int MEM2_ADDR_WIDTH = 10
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         gemm_start_i,
   output logic                         gemm_busy_o,
   output logic                         gemm_done_o,
   output logic                         mem0_ce0_o,
   output logic                         mem0_we0_o,
   output logic [MEM0_ADDR_WIDTH-1:0]   mem0_addr0_o,
   output logic                         mem1_ce0_o,
   output logic                         mem1_we0_o,
   output logic [MEM1_ADDR_WIDTH-1:0]   mem1_addr0_o,
   output logic                         w_load_o,
   output logic                         ifmap_vld_o,
   output logic                         acc_clr_o,
   output logic [$clog2(PE_SIZE)-1:0]   out_sel_o,
   output logic                         mem2_ce0_o,
   output logic                         mem2_we0_o,
   output logic [MEM2_ADDR_WIDTH-1:0]   mem2_addr0_o
);

   localparam int K_W   = cnt_width(PE_SIZE);
   localparam int D_W   = cnt_width(DRAIN_CYC);
   localparam int R_W   = cnt_width(ROW_TILES);
   localparam int C_W   = cnt_width(COL_TILES);
   localparam int SEL_W = $clog2(PE_SIZE);

   localparam logic [K_W-1:0] K_MAX = K_W'(PE_SIZE - 1);
   localparam logic [D_W-1:0] D_MAX = D_W'(DRAIN_CYC - 1);
   localparam logic [R_W-1:0] R_MAX = R_W'(ROW_TILES - 1);
   localparam logic [C_W-1:0] C_MAX = C_W'(COL_TILES - 1);

   // Highest address each BRAM will see must fit its port, and the drain must cover the skew.
   if ((COL_TILES * ROW_TILES * PE_SIZE > (1 << MEM1_ADDR_WIDTH)) ||
       (ROW_TILES * PE_SIZE > (1 << MEM0_ADDR_WIDTH)) ||
       (COL_TILES * PE_SIZE > (1 << MEM2_ADDR_WIDTH)) ||
       (DRAIN_CYC < 2 * PE_SIZE - 1) || (PE_SIZE < 2)) begin : g_bad_params
      $error("gemm_tile_sched: parameter set does not fit address widths or drain length");
   end

   state_t state_reg, state_next;

   logic           k_en, k_clr, k_last;
   logic           d_en, d_clr, d_last;
   logic           rt_en, rt_clr, rt_last;
   logic           ct_en, ct_clr, ct_last;
   logic [K_W-1:0] k_cnt;
   logic [D_W-1:0] d_cnt;
   logic [R_W-1:0] rt_cnt;
   logic [C_W-1:0] ct_cnt;

   gemm_loop_cnt #(.WIDTH(K_W)) u_k_cnt (
      .clk(clk), .rst_n(rst_n), .en(k_en), .clr(k_clr), .max(K_MAX), .cnt(k_cnt), .last(k_last)
   );
   gemm_loop_cnt #(.WIDTH(D_W)) u_d_cnt (
      .clk(clk), .rst_n(rst_n), .en(d_en), .clr(d_clr), .max(D_MAX), .cnt(d_cnt), .last(d_last)
   );
   gemm_loop_cnt #(.WIDTH(R_W)) u_rt_cnt (
      .clk(clk), .rst_n(rst_n), .en(rt_en), .clr(rt_clr), .max(R_MAX), .cnt(rt_cnt), .last(rt_last)
   );
   gemm_loop_cnt #(.WIDTH(C_W)) u_ct_cnt (
      .clk(clk), .rst_n(rst_n), .en(ct_en), .clr(ct_clr), .max(C_MAX), .cnt(ct_cnt), .last(ct_last)
   );

   logic [31:0] w_addr_full, f_addr_full, o_addr_full;

   assign w_addr_full = (32'(ct_cnt) * ROW_TILES + 32'(rt_cnt)) * PE_SIZE + 32'(k_cnt);
   assign f_addr_full = 32'(rt_cnt) * PE_SIZE + 32'(k_cnt);
   assign o_addr_full = 32'(ct_cnt) * PE_SIZE + 32'(k_cnt);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // k is shared by LOAD_W, FEED and WRITE; it wraps to 0 on its own at each phase end.
   always_comb begin
      state_next = state_reg;
      k_en       = 1'b0;
      k_clr      = 1'b0;
      d_en       = 1'b0;
      d_clr      = 1'b0;
      rt_en      = 1'b0;
      rt_clr     = 1'b0;
      ct_en      = 1'b0;
      ct_clr     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (gemm_start_i) begin
               state_next = LOAD_W;
               k_clr      = 1'b1;
               d_clr      = 1'b1;
               rt_clr     = 1'b1;
               ct_clr     = 1'b1;
            end
         end
         LOAD_W: begin
            k_en = 1'b1;
            if (k_last) state_next = FEED;
         end
         FEED: begin
            k_en = 1'b1;
            if (k_last) begin
               state_next = DRAIN;
               d_clr      = 1'b1;
            end
         end
         DRAIN: begin
            d_en = 1'b1;
            if (d_last) begin
               rt_en      = 1'b1;
               state_next = rt_last ? WRITE : LOAD_W;
            end
         end
         WRITE: begin
            k_en = 1'b1;
            if (k_last) begin
               ct_en      = 1'b1;
               rt_clr     = 1'b1;
               state_next = ct_last ? DONE : LOAD_W;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   logic                       busy_reg, done_reg;
   logic                       mem0_ce_reg, mem1_ce_reg, mem2_ce_reg;
   logic [MEM0_ADDR_WIDTH-1:0] mem0_addr_reg;
   logic [MEM1_ADDR_WIDTH-1:0] mem1_addr_reg;
   logic [MEM2_ADDR_WIDTH-1:0] mem2_addr_reg;
   logic                       w_load_reg, ifmap_vld_reg, acc_clr_reg;
   logic [SEL_W-1:0]           out_sel_reg;

   // Outputs are a registered image of the current state; addresses hold while their ce is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         mem0_ce_reg   <= 1'b0;
         mem1_ce_reg   <= 1'b0;
         mem2_ce_reg   <= 1'b0;
         mem0_addr_reg <= '0;
         mem1_addr_reg <= '0;
         mem2_addr_reg <= '0;
         w_load_reg    <= 1'b0;
         ifmap_vld_reg <= 1'b0;
         acc_clr_reg   <= 1'b0;
         out_sel_reg   <= '0;
      end else begin
         if (state_reg == IDLE && gemm_start_i) begin
            busy_reg <= 1'b1;
         end else if (state_reg == DONE) begin
            busy_reg <= 1'b0;
         end
         done_reg      <= (state_reg == DONE);
         mem1_ce_reg   <= (state_reg == LOAD_W);
         mem0_ce_reg   <= (state_reg == FEED);
         mem2_ce_reg   <= (state_reg == WRITE);
         acc_clr_reg   <= (state_reg == LOAD_W) && (rt_cnt == '0) && (k_cnt == '0);
         w_load_reg    <= mem1_ce_reg;
         ifmap_vld_reg <= mem0_ce_reg;
         if (state_reg == LOAD_W) mem1_addr_reg <= w_addr_full[MEM1_ADDR_WIDTH-1:0];
         if (state_reg == FEED)   mem0_addr_reg <= f_addr_full[MEM0_ADDR_WIDTH-1:0];
         if (state_reg == WRITE) begin
            mem2_addr_reg <= o_addr_full[MEM2_ADDR_WIDTH-1:0];
            out_sel_reg   <= SEL_W'(k_cnt);
         end
      end
   end

   assign gemm_busy_o  = busy_reg;
   assign gemm_done_o  = done_reg;
   assign mem0_ce0_o   = mem0_ce_reg;
   assign mem0_we0_o   = 1'b0;
   assign mem0_addr0_o = mem0_addr_reg;
   assign mem1_ce0_o   = mem1_ce_reg;
   assign mem1_we0_o   = 1'b0;
   assign mem1_addr0_o = mem1_addr_reg;
   assign w_load_o     = w_load_reg;
   assign ifmap_vld_o  = ifmap_vld_reg;
   assign acc_clr_o    = acc_clr_reg;
   assign out_sel_o    = out_sel_reg;
   assign mem2_ce0_o   = mem2_ce_reg;
   assign mem2_we0_o   = mem2_ce_reg;
   assign mem2_addr0_o = mem2_addr_reg;

endmodule

// File: tb/tb_gemm_tile_sched.sv
// Bench for gemm_tile_sched: small-parameter DUT checked against a tile-walk
// reference model, plus a default-parameter DUT for latency and address range.
module tb_gemm_tile_sched;

   localparam int P   = 2;
   localparam int R   = 2;
   localparam int C   = 2;
   localparam int D   = 4;
   localparam int LAT = C * (R * (2 * P + D) + P) + 2;

   logic clk;
   logic rst_n;
   logic start, big_start;

   logic        busy, done, m0_ce, m0_we, m1_ce, m1_we, w_load, ifmap_vld, acc_clr;
   logic        m2_ce, m2_we;
   logic [12:0] m0_addr;
   logic [10:0] m1_addr;
   logic [9:0]  m2_addr;
   logic [0:0]  out_sel;

   logic        b_busy, b_done, b_m0_ce, b_m0_we, b_m1_ce, b_m1_we, b_wl, b_iv, b_clr;
   logic        b_m2_ce, b_m2_we;
   logic [12:0] b_m0_addr;
   logic [10:0] b_m1_addr;
   logic [9:0]  b_m2_addr;
   logic [3:0]  b_sel;

   gemm_tile_sched #(
      .PE_SIZE(P), .ROW_TILES(R), .COL_TILES(C), .DRAIN_CYC(D)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .gemm_start_i(start),
      .gemm_busy_o(busy), .gemm_done_o(done),
      .mem0_ce0_o(m0_ce), .mem0_we0_o(m0_we), .mem0_addr0_o(m0_addr),
      .mem1_ce0_o(m1_ce), .mem1_we0_o(m1_we), .mem1_addr0_o(m1_addr),
      .w_load_o(w_load), .ifmap_vld_o(ifmap_vld), .acc_clr_o(acc_clr),
      .out_sel_o(out_sel),
      .mem2_ce0_o(m2_ce), .mem2_we0_o(m2_we), .mem2_addr0_o(m2_addr)
   );

   gemm_tile_sched u_big (
      .clk(clk), .rst_n(rst_n), .gemm_start_i(big_start),
      .gemm_busy_o(b_busy), .gemm_done_o(b_done),
      .mem0_ce0_o(b_m0_ce), .mem0_we0_o(b_m0_we), .mem0_addr0_o(b_m0_addr),
      .mem1_ce0_o(b_m1_ce), .mem1_we0_o(b_m1_we), .mem1_addr0_o(b_m1_addr),
      .w_load_o(b_wl), .ifmap_vld_o(b_iv), .acc_clr_o(b_clr),
      .out_sel_o(b_sel),
      .mem2_ce0_o(b_m2_ce), .mem2_we0_o(b_m2_we), .mem2_addr0_o(b_m2_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   int q1[$], q0[$], q2a[$], q2s[$], qclr[$];
   int e1[$], e0[$], e2a[$], e2s[$], eclr[$];
   int viol;

   typedef struct {
      int xa;
      int xb;
      int rst_at;
      int exp_lat;
   } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic cmp_q(input string name, input int act[$], input int exp[$]);
      int bad = -1;
      for (int i = 0; i < act.size() && i < exp.size(); i++)
         if (bad < 0 && act[i] != exp[i]) bad = i;
      chk({name, "_len"}, act.size(), exp.size());
      if (bad >= 0)
         chk({name, "_elem"}, act[bad], exp[bad]);
      else
         chk({name, "_first_bad_idx"}, bad, -1);
   endtask

   // Reference sequence of BRAM accesses derived directly from the tile walk.
   task automatic build_model();
      e1.delete(); e0.delete(); e2a.delete(); e2s.delete(); eclr.delete();
      for (int ct = 0; ct < C; ct++) begin
         eclr.push_back(ct * R * P);
         for (int rt = 0; rt < R; rt++) begin
            for (int k = 0; k < P; k++) e1.push_back((ct * R + rt) * P + k);
            for (int k = 0; k < P; k++) e0.push_back(rt * P + k);
         end
         for (int k = 0; k < P; k++) begin
            e2a.push_back(ct * P + k);
            e2s.push_back(k);
         end
      end
   endtask

   function automatic int out_ones();
      return $countones({busy, done, m0_ce, m0_we, m0_addr, m1_ce, m1_we, m1_addr,
                         w_load, ifmap_vld, acc_clr, out_sel, m2_ce, m2_we, m2_addr});
   endfunction

   // Entered and left on a negedge with start low; start is raised for cycle 0.
   task automatic run_job(input int xa, input int xb, input int rst_at, output int lat_o);
      int p1, p0, pa0, pa1, pa2;
      q1.delete(); q0.delete(); q2a.delete(); q2s.delete(); qclr.delete();
      viol  = 0;
      lat_o = -1;
      p1 = int'(m1_ce); p0 = int'(m0_ce);
      pa0 = int'(m0_addr); pa1 = int'(m1_addr); pa2 = int'(m2_addr);
      start = 1'b1;
      for (int cyc = 1; cyc <= LAT + 20; cyc++) begin
         @(negedge clk);
         start = (cyc == xa) || (cyc == xb);
         if (int'(m0_ce) + int'(m1_ce) + int'(m2_ce) > 1) viol++;
         if (int'(w_load) != p1 || int'(ifmap_vld) != p0) viol++;
         if (!m0_ce && int'(m0_addr) != pa0) viol++;
         if (!m1_ce && int'(m1_addr) != pa1) viol++;
         if (!m2_ce && int'(m2_addr) != pa2) viol++;
         if (m2_we != m2_ce || m0_we || m1_we) viol++;
         if (acc_clr && !m1_ce) viol++;
         if (done ? busy : !busy) viol++;
         if (m1_ce) q1.push_back(int'(m1_addr));
         if (m0_ce) q0.push_back(int'(m0_addr));
         if (m2_ce) begin
            q2a.push_back(int'(m2_addr));
            q2s.push_back(int'(out_sel));
         end
         if (acc_clr) qclr.push_back(int'(m1_addr));
         p1 = int'(m1_ce); p0 = int'(m0_ce);
         pa0 = int'(m0_addr); pa1 = int'(m1_addr); pa2 = int'(m2_addr);
         if (cyc == rst_at) begin
            chk("ifmap_ce_before_reset", int'(m0_ce), 1);
            rst_n = 1'b0;
            start = 1'b0;
            #1;
            chk("output_ones_in_reset", out_ones(), 0);
            @(negedge clk);
            rst_n = 1'b1;
            break;
         end
         if (done) begin
            lat_o = cyc;
            break;
         end
      end
      start = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (done || busy) viol++;
      end
   endtask

   task automatic check_trace(input string tag);
      cmp_q({tag, "_mem1"}, q1, e1);
      cmp_q({tag, "_mem0"}, q0, e0);
      cmp_q({tag, "_mem2addr"}, q2a, e2a);
      cmp_q({tag, "_outsel"}, q2s, e2s);
      cmp_q({tag, "_accclr"}, qclr, eclr);
      chk({tag, "_violations"}, viol, 0);
   endtask

   task automatic run_big();
      int m1max = 0, m2max = 0, nw = 0, lat = -1;
      big_start = 1'b1;
      for (int cyc = 1; cyc <= 7000; cyc++) begin
         @(negedge clk);
         big_start = 1'b0;
         if (b_m1_ce && int'(b_m1_addr) > m1max) m1max = int'(b_m1_addr);
         if (b_m2_ce) begin
            nw++;
            if (int'(b_m2_addr) > m2max) m2max = int'(b_m2_addr);
         end
         if (b_done) begin
            lat = cyc;
            break;
         end
      end
      big_start = 1'b0;
      chk("default_latency", lat, 5 * (21 * 56 + 14) + 2);
      chk("default_max_mem1", m1max, 5 * 21 * 14 - 1);
      chk("default_max_mem2", m2max, 5 * 14 - 1);
      chk("default_writes", nw, 5 * 14);
      $display("default-param run: latency %0d, max mem1 %0d, max mem2 %0d, writes %0d",
               lat, m1max, m2max, nw);
   endtask

   initial begin
      vec_t vt[6];
      int   lat;

      vt[0] = '{0, 0, 0, LAT};
      vt[1] = '{5, 20, 0, LAT};
      vt[2] = '{1, 2, 0, LAT};
      vt[3] = '{0, 0, 12, -1};
      vt[4] = '{LAT - 1, 0, 0, LAT};
      vt[5] = '{0, 0, 0, LAT};

      rst_n = 1'b0;
      start = 1'b0;
      big_start = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_output_ones", out_ones(), 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_output_ones", out_ones(), 0);

      build_model();

      for (int i = 0; i < 6; i++) begin
         run_job(vt[i].xa, vt[i].xb, vt[i].rst_at, lat);
         chk($sformatf("vec%0d_latency", i), lat, vt[i].exp_lat);
         if (vt[i].exp_lat > 0) check_trace($sformatf("vec%0d", i));
         $display("vec %0d: extra starts %0d/%0d, reset at %0d, latency %0d",
                  i, vt[i].xa, vt[i].xb, vt[i].rst_at, lat);
      end

      for (int i = 0; i < 6; i++) begin
         int xa, xb;
         xa = int'($urandom_range(1, LAT - 1));
         xb = int'($urandom_range(1, LAT - 1));
         repeat (int'($urandom_range(0, 5))) @(negedge clk);
         run_job(xa, xb, 0, lat);
         chk($sformatf("rand%0d_latency", i), lat, LAT);
         check_trace($sformatf("rand%0d", i));
         $display("rand %0d: extra starts %0d/%0d, latency %0d", i, xa, xb, lat);
      end

      run_big();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
